// File: rtl/piso_pkg.sv
// Shared types, defaults and sizing helpers for the PISO serializer.
// Build option: define PISO_PARITY_EN to append an even-parity bit to every frame.
package piso_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bit counter must be able to hold FRAME_LEN-1, which is WIDTH when parity is on.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int frame_len(input int width);
`ifdef PISO_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake and serial-output bundle between producer, serializer and wire.
// The serializer takes the slave view; the producer/observer takes the master view.
interface piso_serializer_if
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] data_in;
  logic             s_out;
  logic             s_valid;
  logic             done;

  modport master (
    output load_valid,
    output data_in,
    input  load_ready,
    input  s_out,
    input  s_valid,
    input  done
  );

  modport slave (
    input  load_valid,
    input  data_in,
    output load_ready,
    output s_out,
    output s_valid,
    output done
  );

endinterface

// File: rtl/piso_bit_counter.sv
// Loadable down-counter with terminal-count flag; load has priority over decrement
// and the count holds at zero rather than wrapping.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int CW = cnt_width(DEFAULT_WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_nxt,
  output logic          tc
);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    count_nxt = count;
    if (load) begin
      count_nxt = load_val;
    end else if (dec && (count != '0)) begin
      count_nxt = count - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: MSB-first, one bit per clock, gapless back-to-back frames.
// Build option: PISO_PARITY_EN appends an even-parity bit after the LSB.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  piso_serializer_if.slave   bus
);

  localparam int            FRAME_LEN = frame_len(WIDTH);
  localparam int            CW        = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_IDX  = CW'(FRAME_LEN - 1);

  state_t           state, state_nxt;
  logic             armed;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             tc;
  logic             shifting;
  logic             load_ready;
  logic             accept;
  logic             bit_nxt;
  logic             s_out_nxt, s_valid_nxt, done_nxt;
  logic             s_out_q, s_valid_q, done_q;

  assign shifting = (state == SHIFT);
  assign accept   = bus.load_valid && load_ready;

  // armed keeps load_ready low during reset and for the edge it is released on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (tc && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  piso_bit_counter #(
    .CW (CW)
  ) u_bit_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_val  (LAST_IDX),
    .dec       (shifting),
    .count     (cnt),
    .count_nxt (cnt_nxt),
    .tc        (tc)
  );

  always_comb begin
    shreg_nxt = shreg;
    if (accept) begin
      shreg_nxt = bus.data_in;
    end else if (shifting) begin
      shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
    end
  end

`ifdef PISO_PARITY_EN
  logic parity, parity_nxt;

  assign parity_nxt = accept ? ^bus.data_in : parity;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity <= 1'b0;
    end else begin
      parity <= parity_nxt;
    end
  end
`endif

  // Outputs are precomputed from next-state values so the registered copies line up
  // with the bit the counter and shift register describe in the same cycle.
  always_comb begin
    load_ready  = armed && ((state == IDLE) || tc);
    s_valid_nxt = (state_nxt == SHIFT);
    bit_nxt     = shreg_nxt[WIDTH-1];
`ifdef PISO_PARITY_EN
    if (cnt_nxt == '0) bit_nxt = parity_nxt;
`endif
    s_out_nxt   = s_valid_nxt && bit_nxt;
    done_nxt    = s_valid_nxt && (cnt_nxt == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg     <= '0;
      s_out_q   <= 1'b0;
      s_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      shreg     <= shreg_nxt;
      s_out_q   <= s_out_nxt;
      s_valid_q <= s_valid_nxt;
      done_q    <= done_nxt;
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.s_out      = s_out_q;
  assign bus.s_valid    = s_valid_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer (WIDTH=4); expectations follow PISO_PARITY_EN.
module tb_piso_serializer;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int FL = W + 1;
  localparam logic [FL-1:0] EXP_A  = 5'b10111;  // 1011, parity 1
  localparam logic [FL-1:0] EXP_B1 = 5'b11000;  // 1100, parity 0
  localparam logic [FL-1:0] EXP_B2 = 5'b01100;  // 0110, parity 0
  localparam logic [FL-1:0] EXP_C  = 5'b10010;  // 1001, parity 0
  localparam logic [FL-1:0] EXP_D  = 5'b00011;  // 0001, parity 1
`else
  localparam int FL = W;
  localparam logic [FL-1:0] EXP_A  = 4'b1011;
  localparam logic [FL-1:0] EXP_B1 = 4'b1100;
  localparam logic [FL-1:0] EXP_B2 = 4'b0110;
  localparam logic [FL-1:0] EXP_C  = 4'b1001;
  localparam logic [FL-1:0] EXP_D  = 4'b0001;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  piso_serializer_if #(.WIDTH(W)) bus ();

  piso_serializer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.load_valid = 1'b0;
    bus.data_in = '0;
    tick();
    tick();
    total++; if (bus.load_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", bus.load_ready); end
    total++; if (bus.s_valid !== 1'b0) begin bad++; $display("FAIL reset_s_valid: got %b want 0", bus.s_valid); end
    total++; if (bus.s_out !== 1'b0) begin bad++; $display("FAIL reset_s_out: got %b want 0", bus.s_out); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    rst = 1'b0;
    #1;
    total++; if (bus.load_ready !== 1'b0) begin bad++; $display("FAIL release_ready_before_edge: got %b want 0", bus.load_ready); end
    tick();
    total++; if (bus.load_ready !== 1'b1) begin bad++; $display("FAIL release_ready_after_edge: got %b want 1", bus.load_ready); end
  endtask

  task automatic test_single_frame();
    logic [FL-1:0] exp_bits;
    exp_bits = EXP_A;
    bus.load_valid = 1'b1;
    bus.data_in = 4'b1011;
    tick();
    bus.load_valid = 1'b0;
    bus.data_in = 4'b0100;  // must not disturb the frame in flight
    for (int i = 0; i < FL; i++) begin
      total++; if (bus.s_valid !== 1'b1) begin bad++; $display("FAIL single_s_valid[%0d]: got %b want 1", i, bus.s_valid); end
      total++; if (bus.s_out !== exp_bits[FL-1-i]) begin bad++; $display("FAIL single_s_out[%0d]: got %b want %b", i, bus.s_out, exp_bits[FL-1-i]); end
      total++; if (bus.done !== (i == FL-1)) begin bad++; $display("FAIL single_done[%0d]: got %b want %b", i, bus.done, (i == FL-1)); end
      total++; if (bus.load_ready !== (i == FL-1)) begin bad++; $display("FAIL single_ready[%0d]: got %b want %b", i, bus.load_ready, (i == FL-1)); end
      tick();
    end
    total++; if (bus.s_valid !== 1'b0) begin bad++; $display("FAIL single_idle_s_valid: got %b want 0", bus.s_valid); end
    total++; if (bus.s_out !== 1'b0) begin bad++; $display("FAIL single_idle_s_out: got %b want 0", bus.s_out); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL single_idle_done: got %b want 0", bus.done); end
    total++; if (bus.load_ready !== 1'b1) begin bad++; $display("FAIL single_idle_ready: got %b want 1", bus.load_ready); end
  endtask

  task automatic test_back_to_back();
    logic [2*FL-1:0] exp_bits;
    exp_bits = {EXP_B1, EXP_B2};
    bus.load_valid = 1'b1;
    bus.data_in = 4'b1100;
    tick();
    bus.data_in = 4'b0110;  // held valid; accepted in the last-bit cycle
    for (int i = 0; i < 2*FL; i++) begin
      if (i == FL) bus.load_valid = 1'b0;
      total++; if (bus.s_valid !== 1'b1) begin bad++; $display("FAIL b2b_s_valid[%0d]: got %b want 1", i, bus.s_valid); end
      total++; if (bus.s_out !== exp_bits[2*FL-1-i]) begin bad++; $display("FAIL b2b_s_out[%0d]: got %b want %b", i, bus.s_out, exp_bits[2*FL-1-i]); end
      total++; if (bus.done !== ((i == FL-1) || (i == 2*FL-1))) begin bad++; $display("FAIL b2b_done[%0d]: got %b want %b", i, bus.done, ((i == FL-1) || (i == 2*FL-1))); end
      tick();
    end
    total++; if (bus.s_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle_s_valid: got %b want 0", bus.s_valid); end
  endtask

  task automatic test_ignored_load();
    logic [FL-1:0] exp_bits;
    exp_bits = EXP_C;
    bus.load_valid = 1'b1;
    bus.data_in = 4'b1001;
    tick();
    bus.load_valid = 1'b0;
    for (int i = 0; i < FL; i++) begin
      if (i == 1) begin
        bus.load_valid = 1'b1;
        bus.data_in = 4'b0101;
        total++; if (bus.load_ready !== 1'b0) begin bad++; $display("FAIL ignored_ready: got %b want 0", bus.load_ready); end
      end else if (i == 2) begin
        bus.load_valid = 1'b0;
        bus.data_in = 4'b0000;
      end
      total++; if (bus.s_out !== exp_bits[FL-1-i]) begin bad++; $display("FAIL ignored_s_out[%0d]: got %b want %b", i, bus.s_out, exp_bits[FL-1-i]); end
      total++; if (bus.done !== (i == FL-1)) begin bad++; $display("FAIL ignored_done[%0d]: got %b want %b", i, bus.done, (i == FL-1)); end
      tick();
    end
    total++; if (bus.s_valid !== 1'b0) begin bad++; $display("FAIL ignored_not_captured: s_valid got %b want 0", bus.s_valid); end
  endtask

  task automatic test_mid_frame_reset();
    logic [FL-1:0] exp_bits;
    exp_bits = EXP_D;
    bus.load_valid = 1'b1;
    bus.data_in = 4'b1111;
    tick();
    bus.load_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++; if (bus.s_out !== 1'b1) begin bad++; $display("FAIL abort_pre_s_out[%0d]: got %b want 1", i, bus.s_out); end
      if (i == 0) tick();
    end
    #2;
    rst = 1'b1;
    #1;
    total++; if (bus.s_valid !== 1'b0) begin bad++; $display("FAIL abort_async_s_valid: got %b want 0", bus.s_valid); end
    total++; if (bus.s_out !== 1'b0) begin bad++; $display("FAIL abort_async_s_out: got %b want 0", bus.s_out); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL abort_async_done: got %b want 0", bus.done); end
    total++; if (bus.load_ready !== 1'b0) begin bad++; $display("FAIL abort_async_ready: got %b want 0", bus.load_ready); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < FL; i++) begin
      tick();
      total++; if ((bus.done !== 1'b0) || (bus.s_valid !== 1'b0)) begin bad++; $display("FAIL abort_no_done[%0d]: done=%b s_valid=%b want 0 0", i, bus.done, bus.s_valid); end
    end
    bus.load_valid = 1'b1;
    bus.data_in = 4'b0001;
    tick();
    bus.load_valid = 1'b0;
    for (int i = 0; i < FL; i++) begin
      total++; if (bus.s_valid !== 1'b1) begin bad++; $display("FAIL after_abort_s_valid[%0d]: got %b want 1", i, bus.s_valid); end
      total++; if (bus.s_out !== exp_bits[FL-1-i]) begin bad++; $display("FAIL after_abort_s_out[%0d]: got %b want %b", i, bus.s_out, exp_bits[FL-1-i]); end
      total++; if (bus.done !== (i == FL-1)) begin bad++; $display("FAIL after_abort_done[%0d]: got %b want %b", i, bus.done, (i == FL-1)); end
      tick();
    end
    total++; if (bus.s_valid !== 1'b0) begin bad++; $display("FAIL after_abort_idle: s_valid got %b want 0", bus.s_valid); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_ignored_load();
    test_mid_frame_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
